// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake and the instruction memory write port
//   of the boot loader.
//   rx_valid/rx_data : byte source -> loader
//   rx_ready         : loader -> byte source
//   mem_we/mem_addr/mem_wdata : loader -> instruction memory write port
//   master modport : the loader side
//   slave modport  : the environment (byte source + memory)
interface imem_loader_if #(
    parameter int N_Bits = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [N_Bits-1:0] mem_addr;
    logic [N_Bits-1:0] mem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction memory writer. Receives a program image as a byte
//   stream (count N, 4*N little-endian data bytes, 8-bit sum checksum),
//   writes each assembled word at byte address word_index*4 and keeps the CPU
//   in hold until a complete image with a good checksum has been written.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : one-cycle pulse starting a load, ignored while busy
//   bus        : rx handshake + memory write port (imem_loader_if.master)
//   cpu_hold   : 1 = CPU held in reset
//   busy       : load in progress
//   done / err : outcome of the last load
module imem_loader #(
    parameter int N_Bits = 32,
    parameter int DEPTH  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int IDXW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERROR} state_t;

    state_t         state, state_nx;
    logic           xfer;
    logic           start_acc;
    logic [1:0]     byte_idx;
    logic [IDXW-1:0] word_idx;
    logic [IDXW-1:0] n_words;
    logic [7:0]     csum;
    logic [23:0]    shift;      // first three bytes of the current word, byte 0 in [7:0]

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign start_acc = start && (state == IDLE || state == DONE || state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = COUNT;
            COUNT: if (xfer) begin
                if (bus.rx_data == 8'd0 || int'(bus.rx_data) > DEPTH) state_nx = ERROR;
                else                                                    state_nx = DATA;
            end
            DATA:  if (xfer && byte_idx == 2'd3 && word_idx == n_words - IDXW'(1))
                state_nx = CHECK;
            CHECK: if (xfer) state_nx = (bus.rx_data == csum) ? DONE : ERROR;
            DONE:  if (start) state_nx = COUNT;
            ERROR: if (start) state_nx = COUNT;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
        end else begin
            bus.rx_ready <= (state_nx == COUNT || state_nx == DATA || state_nx == CHECK);
            busy         <= (state_nx == COUNT || state_nx == DATA || state_nx == CHECK);
            done         <= (state_nx == DONE);
            err          <= (state_nx == ERROR);
            cpu_hold     <= (state_nx != DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx      <= '0;
            word_idx      <= '0;
            n_words       <= '0;
            csum          <= '0;
            shift         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start_acc) begin
                byte_idx <= '0;
                word_idx <= '0;
                csum     <= '0;
            end
            if (state == COUNT && xfer)
                n_words <= IDXW'(bus.rx_data);
            if (state == DATA && xfer) begin
                shift    <= {bus.rx_data, shift[23:8]};
                byte_idx <= byte_idx + 2'd1;
                csum     <= csum + bus.rx_data;
                if (byte_idx == 2'd3) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= N_Bits'({word_idx, 2'b00});
                    bus.mem_wdata <= {bus.rx_data, shift};
                    word_idx      <= word_idx + IDXW'(1);
                end
            end
        end
    end
endmodule
